instr_issue: RTL and testbench

Instruction issue unit that drives the 32-bit `Instruction` bus of the R-type execute stage. It holds a small loadable program memory and steps a word-indexed program counter through it, presenting one instruction per handshake. It stops on a SYSTEM-opcode sentinel, on reaching the last memory word, or on an external stop request.

---
 rtl/instr_issue.sv | 167 ++++++++++++++++
 tb/tb_instr_issue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue.sv
// Instruction issue unit: loadable program memory stepped by a word-indexed
// program counter, offering one instruction per valid/ready handshake and
// halting on a SYSTEM-opcode sentinel, the last memory word, or a stop request.
module instr_issue #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  input  logic          stop,
  input  logic          instr_ready,
  output logic [31:0]   Instruction,
  output logic          instr_valid,
  output logic [31:0]   pc,
  output logic          busy,
  output logic          done,
  output logic [1:0]    halt_cause,
  output logic [15:0]   issue_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    ISSUE = 2'b10,
    DONE  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_SENTINEL = 2'b01,
    CAUSE_END      = 2'b10,
    CAUSE_ABORT    = 2'b11
  } cause_t;

  localparam logic [6:0]    SYS_OPCODE = 7'b1110011;
  localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);

  logic [31:0]   mem_q [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] pc_idx_q, pc_idx_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  cause_t        cause_q, cause_d;
  logic [15:0]   count_q, count_d;
  logic          mem_we;

  logic [AW-1:0] next_idx;
  logic [31:0]   cur_word;
  logic [31:0]   next_word;
  logic          cur_is_sentinel;
  logic          next_is_sentinel;
  logic          xfer;

  // Combinational reads of the current and following program words.
  always_comb begin
    next_idx         = pc_idx_q + AW'(1);
    cur_word         = mem_q[pc_idx_q];
    next_word        = mem_q[next_idx];
    cur_is_sentinel  = (cur_word[6:0] == SYS_OPCODE);
    next_is_sentinel = (next_word[6:0] == SYS_OPCODE);
    xfer             = valid_q && instr_ready;
  end

  // Next-state logic: sequencing, halt detection and program-write gating.
  always_comb begin
    state_d  = state_q;
    pc_idx_d = pc_idx_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    cause_d  = cause_q;
    count_d  = count_q;
    mem_we   = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        mem_we = load_en;
        if (start) begin
          state_d  = FETCH;
          pc_idx_d = '0;
          count_d  = '0;
          cause_d  = CAUSE_NONE;
        end
      end
      FETCH: begin
        if (stop) begin
          state_d = IDLE;
          cause_d = CAUSE_ABORT;
          valid_d = 1'b0;
        end else if (cur_is_sentinel) begin
          state_d = DONE;
          cause_d = CAUSE_SENTINEL;
        end else begin
          state_d = ISSUE;
          instr_d = cur_word;
          valid_d = 1'b1;
        end
      end
      ISSUE: begin
        // A transfer coinciding with stop still counts; only the advance is dropped.
        if (xfer) begin
          count_d = count_q + 16'd1;
        end
        if (stop) begin
          state_d = IDLE;
          cause_d = CAUSE_ABORT;
          valid_d = 1'b0;
        end else if (xfer) begin
          if (pc_idx_q == LAST_IDX) begin
            state_d = DONE;
            cause_d = CAUSE_END;
            valid_d = 1'b0;
          end else begin
            pc_idx_d = next_idx;
            if (next_is_sentinel) begin
              state_d = DONE;
              cause_d = CAUSE_SENTINEL;
              valid_d = 1'b0;
            end else begin
              instr_d = next_word;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_idx_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      cause_q  <= CAUSE_NONE;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_idx_q <= pc_idx_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      cause_q  <= cause_d;
      count_q  <= count_d;
    end
  end

  // Program memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign Instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = {{(30 - AW){1'b0}}, pc_idx_q, 2'b00};
  assign busy        = (state_q == FETCH) || (state_q == ISSUE);
  assign done        = (state_q == DONE);
  assign halt_cause  = cause_q;
  assign issue_count = count_q;

endmodule

// File: tb/tb_instr_issue.sv
// Self-checking bench for instr_issue: a vector table for the basic program,
// hand-written multi-cycle sequences, and a randomized run against a
// transaction-level reference model.
module tb_instr_issue;

  logic        clk = 1'b0;
  logic        rst, load_en, start, stop, instr_ready;
  logic [4:0]  load_addr;
  logic [31:0] load_data;
  logic [31:0] Instruction, pc;
  logic        instr_valid, busy, done;
  logic [1:0]  halt_cause;
  logic [15:0] issue_count;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] W_ADD = 32'h002081B3;
  localparam logic [31:0] W_SUB = 32'h402081B3;
  localparam logic [31:0] W_XOR = 32'h0020C1B3;
  localparam logic [31:0] W_SYS = 32'h00000073;

  instr_issue #(.DEPTH(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stop(stop),
    .instr_ready(instr_ready), .Instruction(Instruction),
    .instr_valid(instr_valid), .pc(pc), .busy(busy), .done(done),
    .halt_cause(halt_cause), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_instr, input logic e_valid,
                         input logic [31:0] e_pc, input logic e_busy, input logic e_done,
                         input logic [1:0] e_cause, input logic [15:0] e_cnt);
    chk({tag, ".instr"}, Instruction, e_instr);
    chk({tag, ".valid"}, 32'(instr_valid), 32'(e_valid));
    chk({tag, ".pc"},    pc, e_pc);
    chk({tag, ".busy"},  32'(busy), 32'(e_busy));
    chk({tag, ".done"},  32'(done), 32'(e_done));
    chk({tag, ".cause"}, 32'(halt_cause), 32'(e_cause));
    chk({tag, ".count"}, 32'(issue_count), 32'(e_cnt));
  endtask

  // Drive one cycle of inputs, then sample #1 after the rising edge.
  task automatic step(input logic r, input logic ld, input logic [4:0] la,
                      input logic [31:0] ldat, input logic st, input logic sp,
                      input logic rdy);
    rst = r; load_en = ld; load_addr = la; load_data = ldat;
    start = st; stop = sp; instr_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [32];
  bit          m_run, m_fin, m_off;
  int          m_idx;
  logic [31:0] m_instr;
  int          m_cause;
  int          m_cnt;

  function automatic bit is_sent(input logic [31:0] w);
    return w[6:0] == 7'h73;
  endfunction

  // One clock of the issue rules: running = executing a program,
  // offering = an instruction is presented, finished = halted normally.
  task automatic model_step(input logic r, input logic ld, input logic [4:0] la,
                            input logic [31:0] ldat, input logic st, input logic sp,
                            input logic rdy);
    bit x;
    if (r) begin
      m_run = 0; m_fin = 0; m_off = 0; m_idx = 0;
      m_instr = '0; m_cause = 0; m_cnt = 0;
    end else if (!m_run) begin
      if (ld) m_mem[la] = ldat;
      if (st) begin
        m_run = 1; m_fin = 0; m_idx = 0; m_cnt = 0; m_cause = 0;
      end
    end else begin
      x = m_off && rdy;
      if (x) m_cnt = (m_cnt + 1) % 65536;
      if (sp) begin
        m_run = 0; m_off = 0; m_cause = 3;
      end else if (!m_off) begin
        if (is_sent(m_mem[m_idx])) begin
          m_run = 0; m_fin = 1; m_cause = 1;
        end else begin
          m_instr = m_mem[m_idx]; m_off = 1;
        end
      end else if (x) begin
        if (m_idx == 31) begin
          m_run = 0; m_fin = 1; m_off = 0; m_cause = 2;
        end else begin
          m_idx++;
          if (is_sent(m_mem[m_idx])) begin
            m_run = 0; m_fin = 1; m_off = 0; m_cause = 1;
          end else begin
            m_instr = m_mem[m_idx];
          end
        end
      end
    end
  endtask

  task automatic rstep(input logic r, input logic ld, input logic [4:0] la,
                       input logic [31:0] ldat, input logic st, input logic sp,
                       input logic rdy);
    model_step(r, ld, la, ldat, st, sp, rdy);
    step(r, ld, la, ldat, st, sp, rdy);
    chk_all("rand", m_instr, m_off, 32'(m_idx * 4), m_run, m_fin && !m_run,
            2'(m_cause), 16'(m_cnt));
  endtask

  function automatic logic [31:0] rword();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 5) == 0) w[6:0] = 7'h73;
    else if (w[6:0] == 7'h73) w[0] = 1'b0;
    return w;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        r, ld;
    logic [4:0]  la;
    logic [31:0] ldat;
    logic        st, sp, rdy;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_busy, e_done;
    logic [1:0]  e_cause;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt [11];

  initial begin
    int xfers;
    bool_dummy: begin end

    //            r  ld  la    ldat   st sp rdy  instr  v  pc     b  d  cause  cnt
    vt[0]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 16'd0};
    vt[1]  = '{1'b0, 1'b1, 5'd0, W_ADD, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 16'd0};
    vt[2]  = '{1'b0, 1'b1, 5'd1, W_SUB, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 16'd0};
    vt[3]  = '{1'b0, 1'b1, 5'd2, W_XOR, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 16'd0};
    vt[4]  = '{1'b0, 1'b1, 5'd3, W_SYS, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 16'd0};
    vt[5]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'd0, 1'b1, 1'b0, 2'd0, 16'd0};
    vt[6]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, W_ADD, 1'b1, 32'd0, 1'b1, 1'b0, 2'd0, 16'd0};
    vt[7]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, W_SUB, 1'b1, 32'd4, 1'b1, 1'b0, 2'd0, 16'd1};
    vt[8]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, W_XOR, 1'b1, 32'd8, 1'b1, 1'b0, 2'd0, 16'd2};
    vt[9]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, W_XOR, 1'b0, 32'd12, 1'b0, 1'b1, 2'd1, 16'd3};
    vt[10] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, W_XOR, 1'b0, 32'd12, 1'b0, 1'b1, 2'd1, 16'd3};

    rst = 1'b1; load_en = 0; load_addr = '0; load_data = '0;
    start = 0; stop = 0; instr_ready = 0;

    // Three-word program with ready held high.
    for (int i = 0; i < 11; i++) begin
      step(vt[i].r, vt[i].ld, vt[i].la, vt[i].ldat, vt[i].st, vt[i].sp, vt[i].rdy);
      chk_all($sformatf("vec%0d", i), vt[i].e_instr, vt[i].e_valid, vt[i].e_pc,
              vt[i].e_busy, vt[i].e_done, vt[i].e_cause, vt[i].e_cnt);
    end

    // Backpressure on the second word.
    step(0, 0, 0, 0, 1, 0, 0);
    chk_all("bp.fetch", W_XOR, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_all("bp.w0", W_ADD, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk_all("bp.w1", W_SUB, 1, 4, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      chk_all($sformatf("bp.hold%0d", i), W_SUB, 1, 4, 1, 0, 0, 1);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    chk_all("bp.w2", W_XOR, 1, 8, 1, 0, 0, 2);
    step(0, 0, 0, 0, 0, 0, 1);
    chk_all("bp.done", W_XOR, 0, 12, 0, 1, 1, 3);

    // Stop coinciding with the transfer of word 1.
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_all("stop.w0", W_ADD, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk_all("stop.w1", W_SUB, 1, 4, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    chk_all("stop.abort", W_SUB, 0, 4, 0, 0, 3, 2);

    // Immediate sentinel at word 0.
    step(0, 1, 0, W_SYS, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    chk_all("sent.fetch", W_SUB, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk_all("sent.done", W_SUB, 0, 0, 0, 1, 1, 0);

    // End of memory: all words non-sentinel.
    for (int k = 0; k < 32; k++) step(0, 1, 5'(k), W_ADD, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    xfers = 0;
    for (int g = 0; g < 40 && instr_valid === 1'b1; g++) begin
      chk($sformatf("eom.pc%0d", xfers), pc, 32'(xfers * 4));
      step(0, 0, 0, 0, 0, 0, 1);
      xfers++;
    end
    chk("eom.transfers", 32'(xfers), 32'd32);
    chk_all("eom.done", W_ADD, 0, 124, 0, 1, 2, 32);

    // Reset mid-ISSUE, ignored load during ISSUE, restart.
    step(0, 1, 1, W_SUB, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_all("rst.w0", W_ADD, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk_all("rst.w1", W_SUB, 1, 4, 1, 0, 0, 1);
    step(0, 1, 0, 32'hDEADBEEF, 0, 0, 0);
    chk_all("rst.ldign", W_SUB, 1, 4, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1, 0, 1);
    chk_all("rst.zero", 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_all("rst.restart0", W_ADD, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk_all("rst.restart1", W_SUB, 1, 4, 1, 0, 0, 1);

    // Load and start in the same cycle: FETCH sees the new word.
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0, W_XOR, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_all("ldst.w0", W_XOR, 1, 0, 1, 0, 0, 0);

    // Randomized run against the reference model.
    rstep(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 32; k++) rstep(0, 1, 5'(k), rword(), 0, 0, $urandom_range(0, 1));
    for (int c = 0; c < 3000; c++) begin
      rstep($urandom_range(0, 149) == 0,
            $urandom_range(0, 3) == 0,
            5'($urandom_range(0, 31)),
            rword(),
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
